// File: rtl/wb_seq_mult_slave.sv
// Wishbone classic slave wrapping a WIDTH-cycle shift-add multiplier.
// Operands in, status/product out, single-cycle registered ack, irq pulse on completion.
module wb_seq_mult_slave #(
    parameter int unsigned WIDTH     = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             irq_q, irq_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;

    logic             req_s;
    logic             oper_wr_s;
    logic             busy_s;
    logic [31:0]      rdata_s;
    logic             unused_s;

    // Byte selects, address LSBs and unused write-data bits carry no meaning here.
    assign unused_s  = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    // The !ack term makes a held strobe re-sample only every other cycle.
    assign req_s     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
    assign oper_wr_s = req_s & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
    assign busy_s    = (state_q == S_BUSY);

    // Read-data mux; sees pre-update register values.
    always_comb begin
        rdata_s = 32'h0;
        case (wbs_adr_i[3:2])
            2'd0:    rdata_s[PW-1:0] = {a_q, b_q};
            2'd1:    rdata_s[2:0]    = {err_q, done_q, busy_s};
            2'd2:    rdata_s[PW-1:0] = prod_q;
            default: rdata_s         = 32'h0;
        endcase
    end

    // Next-state logic for bus response and multiplier FSM.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        irq_d   = 1'b0;
        ack_d   = req_s;
        if (req_s && !wbs_we_i) begin
            dat_d = rdata_s;
        end else begin
            dat_d = 32'h0;
        end

        case (state_q)
            S_IDLE: begin
                if (oper_wr_s) begin
                    a_d     = wbs_dat_i[PW-1:WIDTH];
                    b_d     = wbs_dat_i[WIDTH-1:0];
                    prod_d  = {PW{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (b_q[cnt_q]) begin
                    prod_d = prod_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
                end else begin
                    prod_d = prod_q;
                end
                cnt_d = cnt_q + CW'(1);
                // A start request while busy is acked but only flags the error.
                if (oper_wr_s) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                end else begin
                    state_d = S_BUSY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            prod_q  <= {PW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;
endmodule

// File: tb/tb_wb_seq_mult_slave.sv
// Self-checking bench for wb_seq_mult_slave: scoreboarded reads, timing checks on ack and irq.
module tb_wb_seq_mult_slave;
    localparam logic [31:0] OPER   = 32'h3000_0000;
    localparam logic [31:0] STATUS = 32'h3000_0004;
    localparam logic [31:0] RESULT = 32'h3000_0008;
    localparam logic [31:0] RSVD   = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    wb_seq_mult_slave #(.WIDTH(8), .BASE_ADDR(32'h3000_0000)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .irq_o     (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus access; read expectations go through the scoreboard queue.
    task automatic wb_xfer(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp);
        bit got;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        if (!w) exp_q.push_back(exp);
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            step();
            got = ack;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!got) begin
            check_eq({tag, "_ack"}, 32'd0, 32'd1);
            if (!w) void'(exp_q.pop_back());
        end else if (!w) begin
            check_eq(tag, rdat, exp_q.pop_front());
        end else begin
            check_eq({tag, "_wdat0"}, rdat, 32'h0);
        end
    endtask

    task automatic wait_irq(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = irq;
        end
        check_eq({tag, "_irq"}, {31'd0, got}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'hF;
        adr = 32'h0; wdat = 32'h0;

        // 1: reset
        step(); step();
        check_eq("rst_ack", {31'd0, ack}, 32'd0);
        check_eq("rst_dat", rdat, 32'h0);
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        step();
        wb_xfer("rst_status", 1'b0, STATUS, 32'h0, 32'h0);

        // 2: 0xFF * 0xFF, exact irq timing
        step();
        wb_xfer("t2_wr", 1'b1, OPER, 32'h0000_FFFF, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) step();
            check_eq($sformatf("t2_irq_T%0d", k), {31'd0, irq}, {31'd0, (k == 9)});
        end
        wb_xfer("t2_status", 1'b0, STATUS, 32'h0, 32'h2);
        wb_xfer("t2_result", 1'b0, RESULT, 32'h0, 32'h0000_FE01);
        wb_xfer("t2_oper",   1'b0, OPER,   32'h0, 32'h0000_FFFF);

        // 3: 12*13, busy visible, then zero operand
        wb_xfer("t3_wr", 1'b1, OPER, 32'h0000_0C0D, 32'h0);
        wb_xfer("t3_busy", 1'b0, STATUS, 32'h0, 32'h1);
        wait_irq("t3a");
        wb_xfer("t3_result", 1'b0, RESULT, 32'h0, 32'h0000_009C);
        wb_xfer("t3_wr0", 1'b1, OPER, 32'h0000_0037, 32'h0);
        wait_irq("t3b");
        wb_xfer("t3_result0", 1'b0, RESULT, 32'h0, 32'h0);
        wb_xfer("t3_status0", 1'b0, STATUS, 32'h0, 32'h2);

        // 4: start while busy sets sticky err; next start clears it
        wb_xfer("t4_wr", 1'b1, OPER, 32'h0000_0305, 32'h0);
        step(); step();
        wb_xfer("t4_wr_busy", 1'b1, OPER, 32'h0000_0707, 32'h0);
        wait_irq("t4");
        wb_xfer("t4_status", 1'b0, STATUS, 32'h0, 32'h6);
        wb_xfer("t4_result", 1'b0, RESULT, 32'h0, 32'h0000_000F);
        wb_xfer("t4_oper",   1'b0, OPER,   32'h0, 32'h0000_0305);
        wb_xfer("t4_wr2", 1'b1, OPER, 32'h0000_0202, 32'h0);
        wait_irq("t4b");
        wb_xfer("t4_status2", 1'b0, STATUS, 32'h0, 32'h2);
        wb_xfer("t4_result2", 1'b0, RESULT, 32'h0, 32'h0000_0004);

        // 5: reset mid-operation, with a pending request
        wb_xfer("t5_wr", 1'b1, OPER, 32'h0000_0305, 32'h0);
        step(); step(); step();
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = STATUS;
        step();
        check_eq("t5_rst_ack", {31'd0, ack}, 32'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen |= irq;
        end
        check_eq("t5_no_irq", {31'd0, seen}, 32'd0);
        wb_xfer("t5_status", 1'b0, STATUS, 32'h0, 32'h0);
        wb_xfer("t5_result", 1'b0, RESULT, 32'h0, 32'h0);
        wb_xfer("t5_oper",   1'b0, OPER,   32'h0, 32'h0);

        // 6: reserved offset, out-of-range address, held strobe
        wb_xfer("t6_rsvd", 1'b0, RSVD, 32'h0, 32'h0);
        wb_xfer("t6_rsvd_wr", 1'b1, RSVD, 32'hDEAD_BEEF, 32'h0);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h4000_0000; wdat = 32'h0000_AAAA;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            seen |= ack;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check_eq("t6_oob_noack", {31'd0, seen}, 32'd0);
        check_eq("t6_oob_noirq", {31'd0, irq}, 32'd0);
        wb_xfer("t6_oper_kept", 1'b0, OPER, 32'h0, 32'h0);
        step();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = STATUS;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_eq($sformatf("t6_hold_ack_T%0d", k), {31'd0, ack}, {31'd0, (k == 1 || k == 3)});
        end
        cyc = 1'b0; stb = 1'b0;
        step();
        check_eq("t6_idle_dat0", rdat, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
